// File: rtl/irq_dispatch_pkg.sv
// Shared types, bus-select encodings and helpers for the interrupt dispatch block.
package irq_dispatch_pkg;

  // Dispatch FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUAL    = 3'd1,
    REQ     = 3'd2,
    CLEAR   = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  // Bus select field of the CPU vector; NONE means no bus is requesting
  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_A    = 2'b01;
  localparam logic [1:0] BUS_B    = 2'b10;
  localparam logic [1:0] BUS_C    = 2'b11;

  // Fixed priority: A over B over C
  function automatic logic [1:0] pick_bus(input logic a_act, input logic b_act, input logic c_act);
    logic [1:0] sel;
    if (a_act) begin
      sel = BUS_A;
    end else if (b_act) begin
      sel = BUS_B;
    end else if (c_act) begin
      sel = BUS_C;
    end else begin
      sel = BUS_NONE;
    end
    return sel;
  endfunction

  // Position of a channel in the flat clear vector: bus_index*num_ch + chan
  function automatic int unsigned clr_bit_index(input logic [1:0]  bus_sel,
                                                input int unsigned chan,
                                                input int unsigned num_ch);
    int unsigned bus_idx;
    case (bus_sel)
      BUS_A:   bus_idx = 32'd0;
      BUS_B:   bus_idx = 32'd1;
      BUS_C:   bus_idx = 32'd2;
      default: bus_idx = 32'd0;
    endcase
    return (bus_idx * num_ch) + chan;
  endfunction

endpackage

// File: rtl/irq_stable_filter.sv
// Synchronises the encoder outputs and cpu_ack, picks the winning bus and
// requires STABLE_CYC identical {bus, id} samples before flagging a request.
module irq_stable_filter
  import irq_dispatch_pkg::*;
#(
  parameter int unsigned ID_W       = 4,
  parameter int unsigned STABLE_CYC = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            bus_a_act,
  input  logic            bus_b_act,
  input  logic            bus_c_act,
  input  logic [ID_W-1:0] enc_id,
  input  logic            cpu_ack,
  output logic            any_act,
  output logic            qual_valid,
  output logic [ID_W+1:0] qual_tuple,
  output logic            ack_sync
);

  localparam logic [3:0] STAB_C = 4'(STABLE_CYC);

  logic [2:0]      flag_s1_r;
  logic [2:0]      flag_s2_r;
  logic [ID_W-1:0] id_s1_r;
  logic [ID_W-1:0] id_s2_r;
  logic            ack_s1_r;
  logic            ack_s2_r;
  logic [1:0]      bus_sel_s;
  logic [ID_W+1:0] cur_tuple_s;
  logic [ID_W+1:0] tuple_r;
  logic [3:0]      stab_cnt_r;

  // Two-flop synchronisers: encoder outputs may glitch while the encoder settles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_s1_r <= 3'b000;
      flag_s2_r <= 3'b000;
      id_s1_r   <= {ID_W{1'b0}};
      id_s2_r   <= {ID_W{1'b0}};
      ack_s1_r  <= 1'b0;
      ack_s2_r  <= 1'b0;
    end else begin
      flag_s1_r <= {bus_c_act, bus_b_act, bus_a_act};
      flag_s2_r <= flag_s1_r;
      id_s1_r   <= enc_id;
      id_s2_r   <= id_s1_r;
      ack_s1_r  <= cpu_ack;
      ack_s2_r  <= ack_s1_r;
    end
  end

  // Priority pick and current sample tuple
  always_comb begin
    bus_sel_s   = pick_bus(flag_s2_r[0], flag_s2_r[1], flag_s2_r[2]);
    cur_tuple_s = {bus_sel_s, id_s2_r};
  end

  // Stability counter: restart on any tuple change, hold once qualified
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tuple_r    <= {(ID_W+2){1'b0}};
      stab_cnt_r <= 4'd0;
    end else if (!en || (bus_sel_s == BUS_NONE)) begin
      stab_cnt_r <= 4'd0;
    end else if ((stab_cnt_r == 4'd0) || (cur_tuple_s != tuple_r)) begin
      tuple_r    <= cur_tuple_s;
      stab_cnt_r <= 4'd1;
    end else if (stab_cnt_r != STAB_C) begin
      stab_cnt_r <= stab_cnt_r + 4'd1;
    end else begin
      stab_cnt_r <= stab_cnt_r;
    end
  end

  assign any_act    = (bus_sel_s != BUS_NONE);
  assign qual_valid = (stab_cnt_r == STAB_C);
  assign qual_tuple = tuple_r;
  assign ack_sync   = ack_s2_r;

endmodule

// File: rtl/irq_dispatch_ctrl.sv
// Service end of the three-bus priority interrupt encoder: qualifies a
// request, runs the irq/ack handshake with the CPU and pulses the channel clear.
module irq_dispatch_ctrl
  import irq_dispatch_pkg::*;
#(
  parameter int unsigned NUM_CH      = 9,
  parameter int unsigned ID_W        = 4,
  parameter int unsigned STABLE_CYC  = 3,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned HOLDOFF_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bus_a_act,
  input  logic                bus_b_act,
  input  logic                bus_c_act,
  input  logic [ID_W-1:0]     enc_id,
  output logic                cpu_irq,
  output logic [ID_W+1:0]     cpu_vec,
  input  logic                cpu_ack,
  output logic [3*NUM_CH-1:0] chan_clr,
  output logic                busy,
  output logic                err_pulse
);

  localparam int unsigned CLR_W = 3 * NUM_CH;
  localparam logic [CLR_W-1:0] ONE_C = {{(CLR_W-1){1'b0}}, 1'b1};
  localparam logic [15:0] TO_LAST_C = 16'(ACK_TIMEOUT - 1);
  // HOLDOFF_CYC of 0 still spends a single cycle in HOLDOFF
  localparam logic [3:0] HO_LAST_C = (HOLDOFF_CYC == 0) ? 4'd0 : 4'(HOLDOFF_CYC - 1);

  state_t          state_r;
  logic [15:0]     to_cnt_r;
  logic [3:0]      ho_cnt_r;
  logic            ack_prev_r;
  logic            cpu_irq_r;
  logic [ID_W+1:0] cpu_vec_r;
  logic [CLR_W-1:0] chan_clr_r;
  logic            busy_r;
  logic            err_pulse_r;

  logic            filt_en_s;
  logic            any_act_s;
  logic            qual_valid_s;
  logic [ID_W+1:0] qual_tuple_s;
  logic            ack_sync_s;
  logic            ack_rise_s;
  logic            id_illegal_s;
  logic [CLR_W-1:0] clr_onehot_s;

  irq_stable_filter #(
    .ID_W       (ID_W),
    .STABLE_CYC (STABLE_CYC)
  ) u_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (filt_en_s),
    .bus_a_act  (bus_a_act),
    .bus_b_act  (bus_b_act),
    .bus_c_act  (bus_c_act),
    .enc_id     (enc_id),
    .cpu_ack    (cpu_ack),
    .any_act    (any_act_s),
    .qual_valid (qual_valid_s),
    .qual_tuple (qual_tuple_s),
    .ack_sync   (ack_sync_s)
  );

  // Filter only runs while looking for a request; HOLDOFF and service ignore inputs
  always_comb begin
    if ((state_r == IDLE) || (state_r == QUAL)) begin
      filt_en_s = 1'b1;
    end else begin
      filt_en_s = 1'b0;
    end
  end

  // Ack edge detect, index legality and the one-hot clear for the latched vector
  always_comb begin
    ack_rise_s   = ack_sync_s & ~ack_prev_r;
    id_illegal_s = (32'(qual_tuple_s[ID_W-1:0]) >= NUM_CH);
    clr_onehot_s = ONE_C << clr_bit_index(cpu_vec_r[ID_W+1:ID_W],
                                          32'(cpu_vec_r[ID_W-1:0]), NUM_CH);
  end

  // Dispatch FSM with its timeout and holdoff counters; all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      to_cnt_r    <= 16'd0;
      ho_cnt_r    <= 4'd0;
      ack_prev_r  <= 1'b0;
      cpu_irq_r   <= 1'b0;
      cpu_vec_r   <= {(ID_W+2){1'b0}};
      chan_clr_r  <= {CLR_W{1'b0}};
      busy_r      <= 1'b0;
      err_pulse_r <= 1'b0;
    end else begin
      ack_prev_r  <= ack_sync_s;
      err_pulse_r <= 1'b0;
      chan_clr_r  <= {CLR_W{1'b0}};
      case (state_r)
        IDLE: begin
          if (any_act_s) begin
            state_r <= QUAL;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        QUAL: begin
          if (qual_valid_s) begin
            if (id_illegal_s) begin
              err_pulse_r <= 1'b1;
              ho_cnt_r    <= 4'd0;
              state_r     <= HOLDOFF;
            end else begin
              cpu_vec_r   <= qual_tuple_s;
              cpu_irq_r   <= 1'b1;
              to_cnt_r    <= 16'd0;
              state_r     <= REQ;
            end
          end else if (!any_act_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= QUAL;
          end
        end
        REQ: begin
          // An ack edge in the timeout cycle still wins
          if (ack_rise_s) begin
            cpu_irq_r  <= 1'b0;
            chan_clr_r <= clr_onehot_s;
            state_r    <= CLEAR;
          end else if (to_cnt_r == TO_LAST_C) begin
            cpu_irq_r   <= 1'b0;
            err_pulse_r <= 1'b1;
            ho_cnt_r    <= 4'd0;
            state_r     <= HOLDOFF;
          end else begin
            to_cnt_r <= to_cnt_r + 16'd1;
          end
        end
        CLEAR: begin
          ho_cnt_r <= 4'd0;
          state_r  <= HOLDOFF;
        end
        HOLDOFF: begin
          if (ho_cnt_r == HO_LAST_C) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            ho_cnt_r <= ho_cnt_r + 4'd1;
          end
        end
        default: begin
          state_r   <= IDLE;
          cpu_irq_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_irq   = cpu_irq_r;
  assign cpu_vec   = cpu_vec_r;
  assign chan_clr  = chan_clr_r;
  assign busy      = busy_r;
  assign err_pulse = err_pulse_r;

endmodule

// File: tb/tb_irq_dispatch_ctrl.sv
// Self-checking bench for irq_dispatch_ctrl: expected vectors/clear bits are
// queued when a request is driven and compared when the DUT services it.
module tb_irq_dispatch_ctrl;

  localparam int NUM_CH      = 9;
  localparam int ID_W        = 4;
  localparam int STABLE_CYC  = 3;
  localparam int ACK_TIMEOUT = 255;
  localparam int HOLDOFF_CYC = 4;
  localparam int LAT_IRQ     = 2 + STABLE_CYC + 1;
  localparam int LAT_CLR     = 3;
  localparam int CLR_W       = 3 * NUM_CH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             bus_a_act = 1'b0;
  logic             bus_b_act = 1'b0;
  logic             bus_c_act = 1'b0;
  logic [ID_W-1:0]  enc_id = 4'd0;
  logic             cpu_ack = 1'b0;
  logic             cpu_irq;
  logic [ID_W+1:0]  cpu_vec;
  logic [CLR_W-1:0] chan_clr;
  logic             busy;
  logic             err_pulse;

  typedef struct {
    logic [ID_W+1:0] vec;
    int              clr_bit;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  irq_dispatch_ctrl #(
    .NUM_CH(NUM_CH), .ID_W(ID_W), .STABLE_CYC(STABLE_CYC),
    .ACK_TIMEOUT(ACK_TIMEOUT), .HOLDOFF_CYC(HOLDOFF_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_a_act(bus_a_act), .bus_b_act(bus_b_act),
    .bus_c_act(bus_c_act), .enc_id(enc_id), .cpu_irq(cpu_irq), .cpu_vec(cpu_vec),
    .cpu_ack(cpu_ack), .chan_clr(chan_clr), .busy(busy), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Negedges from now until cpu_irq is seen high (bounded)
  task automatic wait_irq(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cpu_irq && k < 60);
  endtask

  // Negedges from now until chan_clr is seen non-zero (bounded)
  task automatic wait_clr(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((chan_clr == {CLR_W{1'b0}}) && k < 60);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cpu_irq, busy, err_pulse} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {cpu_irq, busy, err_pulse});
    end
    n_checks++;
    if (chan_clr !== {CLR_W{1'b0}} || cpu_vec !== 6'd0) begin
      n_fail++; $display("FAIL reset_vec_clr: got vec=%h clr=%h expected 0/0", cpu_vec, chan_clr);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int k; int hb; exp_t e;
    bus_b_act = 1'b1; enc_id = 4'd5;
    exp_q.push_back('{6'b10_0101, 14});
    wait_irq(k);
    n_checks++;
    if (k !== LAT_IRQ) begin n_fail++; $display("FAIL basic_irq_latency: got %0d expected %0d", k, LAT_IRQ); end
    e = exp_q.pop_front();
    n_checks++;
    if (cpu_vec !== e.vec) begin n_fail++; $display("FAIL basic_vec: got %b expected %b", cpu_vec, e.vec); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_req: got %b expected 1", busy); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (cpu_irq !== 1'b1 || cpu_vec !== e.vec) begin
      n_fail++; $display("FAIL basic_irq_hold: got irq=%b vec=%b expected 1/%b", cpu_irq, cpu_vec, e.vec);
    end
    cpu_ack = 1'b1;
    wait_clr(k);
    n_checks++;
    if (k !== LAT_CLR) begin n_fail++; $display("FAIL basic_clr_latency: got %0d expected %0d", k, LAT_CLR); end
    n_checks++;
    if (chan_clr !== (27'b1 << e.clr_bit) || cpu_irq !== 1'b0) begin
      n_fail++; $display("FAIL basic_clr_bit: got clr=%h irq=%b expected bit %0d irq=0", chan_clr, cpu_irq, e.clr_bit);
    end
    bus_b_act = 1'b0;
    @(negedge clk);
    n_checks++;
    if (chan_clr !== {CLR_W{1'b0}}) begin n_fail++; $display("FAIL basic_clr_width: got %h expected 0", chan_clr); end
    hb = busy ? 1 : 0;
    while (busy && hb < 20) begin
      @(negedge clk);
      if (busy) hb++;
    end
    n_checks++;
    if (hb !== HOLDOFF_CYC) begin n_fail++; $display("FAIL basic_holdoff: got %0d busy cycles expected %0d", hb, HOLDOFF_CYC); end
    cpu_ack = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_priority_change();
    int k; exp_t e;
    bus_c_act = 1'b1; enc_id = 4'd2;
    repeat (2) @(negedge clk);
    bus_a_act = 1'b1; enc_id = 4'd7;
    exp_q.push_back('{6'b01_0111, 7});
    wait_irq(k);
    n_checks++;
    if (k !== LAT_IRQ) begin n_fail++; $display("FAIL prio_irq_latency: got %0d expected %0d", k, LAT_IRQ); end
    e = exp_q.pop_front();
    n_checks++;
    if (cpu_vec !== e.vec) begin n_fail++; $display("FAIL prio_vec: got %b expected %b", cpu_vec, e.vec); end
    repeat (2) @(negedge clk);
    cpu_ack = 1'b1;
    wait_clr(k);
    n_checks++;
    if (k !== LAT_CLR || chan_clr !== (27'b1 << e.clr_bit)) begin
      n_fail++; $display("FAIL prio_clr: got k=%0d clr=%h expected k=%0d bit %0d", k, chan_clr, LAT_CLR, e.clr_bit);
    end
    bus_a_act = 1'b0; bus_c_act = 1'b0;
    @(negedge clk);
    cpu_ack = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_illegal_index();
    int k; int hb; int errs; int irq_seen; int clr_seen;
    irq_seen = 0; clr_seen = 0;
    bus_a_act = 1'b1; enc_id = 4'd12;
    k = 0;
    while (!err_pulse && k < 60) begin
      @(negedge clk);
      k++;
      if (cpu_irq) irq_seen++;
      if (chan_clr != {CLR_W{1'b0}}) clr_seen++;
    end
    n_checks++;
    if (k !== LAT_IRQ) begin n_fail++; $display("FAIL illegal_err_latency: got %0d expected %0d", k, LAT_IRQ); end
    bus_a_act = 1'b0;
    hb = busy ? 1 : 0; errs = err_pulse ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) hb++;
      if (err_pulse) errs++;
      if (cpu_irq) irq_seen++;
      if (chan_clr != {CLR_W{1'b0}}) clr_seen++;
    end
    n_checks++;
    if (errs !== 1) begin n_fail++; $display("FAIL illegal_err_count: got %0d expected 1", errs); end
    n_checks++;
    if (irq_seen !== 0 || clr_seen !== 0) begin
      n_fail++; $display("FAIL illegal_no_service: got irq=%0d clr=%0d expected 0/0", irq_seen, clr_seen);
    end
    n_checks++;
    if (hb !== HOLDOFF_CYC || busy !== 1'b0) begin
      n_fail++; $display("FAIL illegal_holdoff: got %0d busy cycles busy=%b expected %0d/0", hb, busy, HOLDOFF_CYC);
    end
  endtask

  task automatic test_timeout();
    int k; int hi; int errs; int bad; exp_t e;
    bus_a_act = 1'b1; enc_id = 4'd3;
    exp_q.push_back('{6'b01_0011, 3});
    wait_irq(k);
    e = exp_q.pop_front();
    n_checks++;
    if (k !== LAT_IRQ || cpu_vec !== e.vec) begin
      n_fail++; $display("FAIL timeout_req: got k=%0d vec=%b expected %0d/%b", k, cpu_vec, LAT_IRQ, e.vec);
    end
    hi = 1; errs = 0;
    while (cpu_irq && hi < 400) begin
      @(negedge clk);
      if (cpu_irq) hi++;
      if (cpu_irq && err_pulse) errs++;
    end
    n_checks++;
    if (hi !== ACK_TIMEOUT) begin n_fail++; $display("FAIL timeout_irq_width: got %0d expected %0d", hi, ACK_TIMEOUT); end
    n_checks++;
    if (err_pulse !== 1'b1 || chan_clr !== {CLR_W{1'b0}} || errs !== 0) begin
      n_fail++; $display("FAIL timeout_err: got err=%b clr=%h early=%0d expected 1/0/0", err_pulse, chan_clr, errs);
    end
    bus_a_act = 1'b0;
    repeat (10) @(negedge clk);
    bad = 0;
    cpu_ack = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) cpu_ack = 1'b0;
      if (cpu_irq || busy || chan_clr != {CLR_W{1'b0}}) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL late_ack_ignored: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_ack_at_timeout();
    int k; exp_t e;
    bus_c_act = 1'b1; enc_id = 4'd6;
    exp_q.push_back('{6'b11_0110, 24});
    wait_irq(k);
    e = exp_q.pop_front();
    n_checks++;
    if (cpu_vec !== e.vec) begin n_fail++; $display("FAIL ackto_vec: got %b expected %b", cpu_vec, e.vec); end
    repeat (ACK_TIMEOUT - LAT_CLR) @(negedge clk);
    cpu_ack = 1'b1;
    repeat (LAT_CLR) @(negedge clk);
    n_checks++;
    if (chan_clr !== (27'b1 << e.clr_bit) || err_pulse !== 1'b0) begin
      n_fail++; $display("FAIL ackto_ack_wins: got clr=%h err=%b expected bit %0d err=0", chan_clr, err_pulse, e.clr_bit);
    end
    bus_c_act = 1'b0;
    @(negedge clk);
    cpu_ack = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_toggle();
    int k; int viol; exp_t e;
    viol = 0;
    bus_a_act = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_irq) viol++;
      enc_id = (i % 2 == 0) ? 4'd3 : 4'd4;
    end
    exp_q.push_back('{6'b01_0100, 4});
    wait_irq(k);
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL toggle_no_irq: got %0d irq cycles expected 0", viol); end
    n_checks++;
    if (k !== LAT_IRQ) begin n_fail++; $display("FAIL toggle_steady_latency: got %0d expected %0d", k, LAT_IRQ); end
    e = exp_q.pop_front();
    n_checks++;
    if (cpu_vec !== e.vec) begin n_fail++; $display("FAIL toggle_vec: got %b expected %b", cpu_vec, e.vec); end
    cpu_ack = 1'b1;
    wait_clr(k);
    n_checks++;
    if (chan_clr !== (27'b1 << e.clr_bit)) begin
      n_fail++; $display("FAIL toggle_clr: got %h expected bit %0d", chan_clr, e.clr_bit);
    end
    bus_a_act = 1'b0;
    @(negedge clk);
    cpu_ack = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_level_ack();
    int k; int clr_seen; exp_t e;
    cpu_ack = 1'b1;
    repeat (4) @(negedge clk);
    bus_c_act = 1'b1; enc_id = 4'd0;
    exp_q.push_back('{6'b11_0000, 18});
    wait_irq(k);
    e = exp_q.pop_front();
    n_checks++;
    if (k !== LAT_IRQ || cpu_vec !== e.vec) begin
      n_fail++; $display("FAIL level_req: got k=%0d vec=%b expected %0d/%b", k, cpu_vec, LAT_IRQ, e.vec);
    end
    clr_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (chan_clr != {CLR_W{1'b0}} || !cpu_irq) clr_seen++;
    end
    n_checks++;
    if (clr_seen !== 0) begin n_fail++; $display("FAIL level_ack_held: got %0d serviced cycles expected 0", clr_seen); end
    cpu_ack = 1'b0;
    repeat (3) @(negedge clk);
    cpu_ack = 1'b1;
    wait_clr(k);
    n_checks++;
    if (k !== LAT_CLR || chan_clr !== (27'b1 << e.clr_bit)) begin
      n_fail++; $display("FAIL level_reack: got k=%0d clr=%h expected %0d/bit %0d", k, chan_clr, LAT_CLR, e.clr_bit);
    end
    bus_c_act = 1'b0;
    @(negedge clk);
    cpu_ack = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid_req();
    int k; exp_t e;
    bus_b_act = 1'b1; enc_id = 4'd8;
    exp_q.push_back('{6'b10_1000, 17});
    wait_irq(k);
    e = exp_q.pop_front();
    n_checks++;
    if (cpu_vec !== e.vec) begin n_fail++; $display("FAIL rstreq_vec: got %b expected %b", cpu_vec, e.vec); end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cpu_irq, busy} !== 2'b00 || chan_clr !== {CLR_W{1'b0}}) begin
      n_fail++; $display("FAIL rstreq_async_drop: got irq=%b busy=%b clr=%h expected 0/0/0", cpu_irq, busy, chan_clr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back('{6'b10_1000, 17});
    wait_irq(k);
    n_checks++;
    if (k !== LAT_IRQ) begin n_fail++; $display("FAIL rstreq_requal_latency: got %0d expected %0d", k, LAT_IRQ); end
    e = exp_q.pop_front();
    @(negedge clk);
    cpu_ack = 1'b1;
    wait_clr(k);
    n_checks++;
    if (chan_clr !== (27'b1 << e.clr_bit) || cpu_vec !== e.vec) begin
      n_fail++; $display("FAIL rstreq_clr: got clr=%h vec=%b expected bit %0d/%b", chan_clr, cpu_vec, e.clr_bit, e.vec);
    end
    bus_b_act = 1'b0;
    @(negedge clk);
    cpu_ack = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority_change();
    test_illegal_index();
    test_timeout();
    test_ack_at_timeout();
    test_toggle();
    test_level_ack();
    test_reset_mid_req();
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
